// File: rtl/iiitb_rc_param.sv
// iiitb_rc_param: parametrised ring/Johnson counter with period step count, wrap pulse and legality flag.
// Optional RC_SELFCORRECT_EN: a step taken from an illegal pattern loads the mode's recovery pattern.
module iiitb_rc_param #(
    parameter int WIDTH     = 4,
    parameter int RESET_VAL = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          load,
    input  logic                          dir,
    input  logic                          mode,
    input  logic [WIDTH-1:0]              init,
    output logic [WIDTH-1:0]              out,
    output logic [$clog2(2*WIDTH)-1:0]    cnt,
    output logic                          wrap,
    output logic                          err
);
    localparam int CW = $clog2(2*WIDTH);
    localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VAL);

    // Johnson legality: at most one boundary between adjacent differing bits
    function automatic logic legal(input logic [WIDTH-1:0] v, input logic m);
        return m ? ($countones(v[WIDTH-2:0] ^ v[WIDTH-1:1]) <= 1) : ($countones(v) == 1);
    endfunction

    logic [WIDTH-1:0] out_n, step;
    logic [CW-1:0]    cnt_n, last;
    logic             wrap_n, err_n, mode_q, at_end;

    assign step   = dir ? {out[0] ^ mode, out[WIDTH-1:1]} : {out[WIDTH-2:0], out[WIDTH-1] ^ mode};
    assign last   = mode ? CW'(2*WIDTH-1) : CW'(WIDTH-1);
    assign at_end = cnt == last;

    always_comb begin
        out_n  = out;
        cnt_n  = cnt;
        wrap_n = 1'b0;
        if (load) begin
            out_n = init;
            cnt_n = '0;
        end else if (en) begin
`ifdef RC_SELFCORRECT_EN
            if (err) begin
                out_n = mode ? '0 : WIDTH'(1);
                cnt_n = '0;
            end else begin
                out_n  = step;
                cnt_n  = at_end ? '0 : cnt + CW'(1);
                wrap_n = at_end;
            end
`else
            out_n  = step;
            cnt_n  = at_end ? '0 : cnt + CW'(1);
            wrap_n = at_end;
`endif
        end
        if (mode != mode_q) begin
            cnt_n  = '0;
            wrap_n = 1'b0;
        end
        err_n = !legal(out_n, mode);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out    <= RV;
            cnt    <= '0;
            wrap   <= 1'b0;
            err    <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            out    <= out_n;
            cnt    <= cnt_n;
            wrap   <= wrap_n;
            err    <= err_n;
            mode_q <= mode;
        end
    end
endmodule
